// File: rtl/sr_latch_sequencer.sv
// ---------------------------------------------------------------------------
// sr_latch_sequencer
//
// Drives the S/R inputs of an asynchronous NOR SR latch from clocked logic.
// Each accepted command becomes a PULSE_W-cycle pulse on S (set) or R
// (reset), followed by GUARD_W cycles with S=R=0, then a one-cycle CHECK
// state where completion is signalled. S and R are never high together.
//
// Optional feature: define SR_CHECK_EN to compare the latch readback
// (Q/n_Q) against the commanded value in CHECK and raise a sticky err.
// Without it, err is tied low and Q/n_Q are ignored; timing is identical.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   cmd_valid  command present
//   cmd_set    1 = set latch, 0 = reset latch (sampled on accept)
//   cmd_ready  block idle and able to accept a command
//   S, R       registered latch set / reset inputs
//   Q, n_Q     latch readback
//   busy       command in progress
//   done       one-cycle completion pulse
//   state_q    last commanded latch value
//   err        sticky readback mismatch flag
// ---------------------------------------------------------------------------
module sr_latch_sequencer #(
    parameter int PULSE_W = 2,
    parameter int GUARD_W = 1,
    parameter int CNT_W   = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic cmd_valid,
    input  logic cmd_set,
    output logic cmd_ready,
    output logic S,
    output logic R,
    input  logic Q,
    input  logic n_Q,
    output logic busy,
    output logic done,
    output logic state_q,
    output logic err
);

    typedef enum logic [1:0] {IDLE, PULSE, GUARD, CHECK} state_t;

    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] GUARD_LD = CNT_W'(GUARD_W - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_cmd;

    assign cmd_ready = (r_state == IDLE);
    assign busy      = (r_state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_cmd   <= 1'b0;
            S       <= 1'b0;
            R       <= 1'b0;
            done    <= 1'b0;
            state_q <= 1'b0;
`ifdef SR_CHECK_EN
            err     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    // cmd_ready is implied by being in IDLE.
                    if (cmd_valid) begin
                        r_cmd   <= cmd_set;
                        r_cnt   <= PULSE_LD;
                        S       <= cmd_set;
                        R       <= ~cmd_set;
                        r_state <= PULSE;
                    end
                end
                PULSE: begin
                    if (r_cnt == '0) begin
                        S       <= 1'b0;
                        R       <= 1'b0;
                        r_cnt   <= GUARD_LD;
                        r_state <= GUARD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                GUARD: begin
                    // done and state_q are raised on entry so they are
                    // visible during the CHECK cycle itself.
                    if (r_cnt == '0) begin
                        done    <= 1'b1;
                        state_q <= r_cmd;
                        r_state <= CHECK;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                CHECK: begin
`ifdef SR_CHECK_EN
                    // Latch has settled through the guard interval; a
                    // Q==n_Q readback also fails one of these compares.
                    if ((Q != r_cmd) || (n_Q != ~r_cmd))
                        err <= 1'b1;
`endif
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifndef SR_CHECK_EN
    assign err = 1'b0;
    // Readback is deliberately ignored in this build.
    wire w_unused_readback = Q ^ n_Q;
`endif

endmodule
